cfg_shift_register_v2: RTL and testbench



---
 rtl/cfg_shift_register_v2_pkg.sv | 41 ++++
 rtl/cfg_shift_register_v2_if.sv | 32 +++
 rtl/cfg_shift_register_v2_crc8.sv | 36 +++
 rtl/cfg_shift_register_v2.sv | 151 +++++++++++++++
 tb/tb_cfg_shift_register_v2.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/cfg_shift_register_v2_pkg.sv
// -----------------------------------------------------------------------------
// cfg_sreg_pkg
// Shared definitions for the configuration shift register:
//   - CRC8_POLY  : CRC-8 polynomial (x^8 + x^2 + x + 1), non-reflected, init 0
//   - CRC8_MAXW  : widest payload crc8_word() can fold in one call
//   - state_e    : frame controller states
//   - crc8_next  : one serial CRC-8 step (one input bit)
//   - crc8_word  : CRC-8 over the low nbits of a word, MSB first
// -----------------------------------------------------------------------------
package cfg_sreg_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam int         CRC8_MAXW = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Feedback is the outgoing MSB XOR the incoming bit, so the result matches
    // a byte-wise table CRC with the data fed MSB first.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic b);
        return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? CRC8_POLY : 8'h00);
    endfunction

    // Walks the fixed maximum width and only folds in bits below nbits, which
    // keeps the loop bound constant for synthesis.
    function automatic logic [7:0] crc8_word(input logic [CRC8_MAXW-1:0] data,
                                             input int nbits);
        logic [7:0] c;
        c = 8'h00;
        for (int i = CRC8_MAXW - 1; i >= 0; i--) begin
            if (i < nbits) begin
                c = crc8_next(c, data[i]);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/cfg_shift_register_v2_if.sv
// -----------------------------------------------------------------------------
// cfg_shift_register_v2_if
// Serial configuration bus between a GPIO/bit-bang driver and the register.
//   master (driver)  : drives sen, din, latch, capture; observes the rest
//   slave  (register): drives dout, cfg_q, cfg_valid, cfg_update, crc_err,
//                      len_err
// WIDTH must match the WIDTH of the attached register.
// -----------------------------------------------------------------------------
interface cfg_shift_register_v2_if #(
    parameter int WIDTH = 32
);
    logic             sen;
    logic             din;
    logic             latch;
    logic             capture;
    logic             dout;
    logic [WIDTH-1:0] cfg_q;
    logic             cfg_valid;
    logic             cfg_update;
    logic             crc_err;
    logic             len_err;

    modport master (
        output sen, din, latch, capture,
        input  dout, cfg_q, cfg_valid, cfg_update, crc_err, len_err
    );

    modport slave (
        input  sen, din, latch, capture,
        output dout, cfg_q, cfg_valid, cfg_update, crc_err, len_err
    );
endinterface

// File: rtl/cfg_shift_register_v2_crc8.sv
// -----------------------------------------------------------------------------
// cfg_crc8_serial
// Bit-serial CRC-8 accumulator (poly 0x07, init 0x00, no final XOR).
//   clk : clock
//   rst : asynchronous reset, active-high (accumulator -> 0x00)
//   clr : synchronous clear, wins over en
//   en  : fold din into the accumulator this cycle
//   din : serial data bit
//   crc : current accumulator value
// -----------------------------------------------------------------------------
module cfg_crc8_serial
    import cfg_sreg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    logic [7:0] crc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= 8'h00;
        end else if (clr) begin
            crc_q <= 8'h00;
        end else if (en) begin
            crc_q <= crc8_next(crc_q, din);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/cfg_shift_register_v2.sv
// -----------------------------------------------------------------------------
// cfg_shift_register_v2
// Serial configuration register with framed payload (+ optional CRC-8),
// strobed commit into a shadow register, and capture/readback through dout.
// Parameters: WIDTH (payload bits), CRC_EN (frame carries CRC-8),
//             RESET_VAL (cfg_q after reset).
// Ports:
//   clk : shift/config clock
//   rst : asynchronous reset, active-high
//   bus : slave side of cfg_shift_register_v2_if
//         sen/din shift a frame in MSB first, latch commits, capture loads
//         cfg_q back into the shift register, dout is the shift register MSB,
//         cfg_q/cfg_valid/cfg_update/crc_err/len_err report commit results.
// Priority of requests: sen > latch > capture; everything is ignored during
// the single COMMIT cycle.
// -----------------------------------------------------------------------------
module cfg_shift_register_v2
    import cfg_sreg_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter bit               CRC_EN    = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic                     clk,
    input logic                     rst,
    cfg_shift_register_v2_if.slave  bus
);

    localparam int FRAME = WIDTH + (CRC_EN ? 8 : 0);
    localparam int CW    = $clog2(FRAME + 2);

    localparam logic [CW-1:0] CNT_FRAME = CW'(FRAME);
    // FRAME+1 marks "too many bits"; the counter parks there.
    localparam logic [CW-1:0] CNT_OVF   = CW'(FRAME + 1);

    state_e           state_q, state_d;
    logic [FRAME-1:0] sr_q, sr_d;
    logic [FRAME-1:0] sr_capture;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] cfg_val_q, cfg_val_d;
    logic             valid_q, valid_d;
    logic             update_q, update_d;
    logic             crc_err_q, crc_err_d;
    logic             len_err_q, len_err_d;

    logic in_commit;
    logic shift_fire;
    logic latch_fire;
    logic capture_fire;
    logic len_ok;
    logic crc_ok;

    assign in_commit    = (state_q == COMMIT);
    assign shift_fire   = !in_commit && bus.sen;
    assign latch_fire   = !in_commit && !bus.sen && bus.latch;
    assign capture_fire = !in_commit && !bus.sen && !bus.latch && bus.capture;
    assign len_ok       = (cnt_q == CNT_FRAME);

    generate
        if (CRC_EN) begin : g_crc
            localparam logic [CW-1:0] CNT_WIDTH = CW'(WIDTH);
            logic [7:0] crc_w;

            // Only payload bits feed the running CRC; the trailing CRC field
            // itself is shifted in but not folded.
            cfg_crc8_serial u_crc (
                .clk (clk),
                .rst (rst),
                .clr (in_commit || capture_fire),
                .en  (shift_fire && (cnt_q < CNT_WIDTH)),
                .din (bus.din),
                .crc (crc_w)
            );

            assign crc_ok     = (sr_q[7:0] == crc_w);
            assign sr_capture = {cfg_val_q, crc8_word(CRC8_MAXW'(cfg_val_q), WIDTH)};
        end else begin : g_nocrc
            assign crc_ok     = 1'b1;
            assign sr_capture = cfg_val_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            cfg_val_q <= RESET_VAL;
            valid_q   <= 1'b0;
            update_q  <= 1'b0;
            crc_err_q <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            cfg_val_q <= cfg_val_d;
            valid_q   <= valid_d;
            update_q  <= update_d;
            crc_err_q <= crc_err_d;
            len_err_q <= len_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        cfg_val_d = cfg_val_q;
        valid_d   = valid_q;
        update_d  = 1'b0;
        crc_err_d = crc_err_q;
        len_err_d = len_err_q;

        if (in_commit) begin
            // sr is deliberately kept so the last frame can still be shifted out.
            state_d = IDLE;
            cnt_d   = '0;
            if (len_ok && crc_ok) begin
                cfg_val_d = sr_q[FRAME-1 -: WIDTH];
                valid_d   = 1'b1;
                update_d  = 1'b1;
                crc_err_d = 1'b0;
                len_err_d = 1'b0;
            end else begin
                len_err_d = !len_ok;
                crc_err_d = len_ok && !crc_ok;
            end
        end else if (shift_fire) begin
            state_d = SHIFT;
            sr_d    = {sr_q[FRAME-2:0], bus.din};
            if (cnt_q != CNT_OVF) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (latch_fire) begin
            state_d = COMMIT;
        end else if (capture_fire) begin
            state_d = IDLE;
            sr_d    = sr_capture;
            cnt_d   = '0;
        end
    end

    assign bus.dout       = sr_q[FRAME-1];
    assign bus.cfg_q      = cfg_val_q;
    assign bus.cfg_valid  = valid_q;
    assign bus.cfg_update = update_q;
    assign bus.crc_err    = crc_err_q;
    assign bus.len_err    = len_err_q;

endmodule

// File: tb/tb_cfg_shift_register_v2.sv
// -----------------------------------------------------------------------------
// tb_cfg_shift_register_v2
// Directed bench for cfg_shift_register_v2: a WIDTH=32/CRC_EN=1 instance and a
// WIDTH=8/CRC_EN=0 instance sharing clk/rst. Inputs change and outputs are
// sampled on the falling edge.
// Hand-computed CRC-8 (poly 0x07, init 0): 0x00000001 -> 0x07,
// 0x00000000 -> 0x00, 0x00000080 -> 0x89.
// -----------------------------------------------------------------------------
module tb_cfg_shift_register_v2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cfg_shift_register_v2_if #(.WIDTH(32)) b32 ();
    cfg_shift_register_v2_if #(.WIDTH(8))  b8 ();

    cfg_shift_register_v2 #(
        .WIDTH     (32),
        .CRC_EN    (1'b1),
        .RESET_VAL (32'h0000_5A5A)
    ) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    cfg_shift_register_v2 #(
        .WIDTH     (8),
        .CRC_EN    (1'b0),
        .RESET_VAL (8'h3C)
    ) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shift the low n bits of v into the 32-bit instance, MSB first, with
    // latch held at lat throughout. Returns on a falling edge with sen low.
    task automatic shift32(input logic [63:0] v, input int n, input logic lat);
        for (int i = n - 1; i >= 0; i--) begin
            b32.sen   = 1'b1;
            b32.din   = v[i];
            b32.latch = lat;
            @(negedge clk);
        end
        b32.sen   = 1'b0;
        b32.din   = 1'b0;
        b32.latch = 1'b0;
    endtask

    // Latch pulse in cycle N; returns at the falling edge of cycle N+2.
    task automatic latch32();
        b32.latch = 1'b1;
        @(negedge clk);
        b32.latch = 1'b0;
        @(negedge clk);
    endtask

    task automatic capture32();
        b32.capture = 1'b1;
        @(negedge clk);
        b32.capture = 1'b0;
    endtask

    logic [39:0] rb;

    initial begin
        rst = 1'b1;
        b32.sen = 1'b0; b32.din = 1'b0; b32.latch = 1'b0; b32.capture = 1'b0;
        b8.sen  = 1'b0; b8.din  = 1'b0; b8.latch  = 1'b0; b8.capture  = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_cfg_q",      b32.cfg_q,      64'h5A5A);
        check("rst_cfg_valid",  b32.cfg_valid,  0);
        check("rst_cfg_update", b32.cfg_update, 0);
        check("rst_crc_err",    b32.crc_err,    0);
        check("rst_len_err",    b32.len_err,    0);
        check("rst_dout",       b32.dout,       0);
        check("rst_cfg_q_w8",   b8.cfg_q,       64'h3C);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a frame: 17 bits, then async reset away
        // from any edge. A following full frame must be accepted, which
        // needs the bit counter to have restarted from zero.
        shift32(64'h1_FFFF, 17, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_cfg_q", b32.cfg_q, 64'h5A5A);
        check("midrst_dout",  b32.dout,  0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Good frame 0x00000001 / CRC 0x07, with latency checks
        shift32({32'h0000_0001, 8'h07}, 40, 1'b0);
        b32.latch = 1'b1;
        @(negedge clk);
        b32.latch = 1'b0;
        check("good1_n1_cfg_q",  b32.cfg_q,      64'h5A5A);
        check("good1_n1_update", b32.cfg_update, 0);
        @(negedge clk);
        check("good1_cfg_q",   b32.cfg_q,      64'h1);
        check("good1_update",  b32.cfg_update, 1);
        check("good1_valid",   b32.cfg_valid,  1);
        check("good1_crc_err", b32.crc_err,    0);
        check("good1_len_err", b32.len_err,    0);
        @(negedge clk);
        check("good1_update_pulse_end", b32.cfg_update, 0);

        // Bad CRC
        shift32({32'h0000_0001, 8'h06}, 40, 1'b0);
        latch32();
        check("badcrc_crc_err", b32.crc_err,    1);
        check("badcrc_len_err", b32.len_err,    0);
        check("badcrc_cfg_q",   b32.cfg_q,      64'h1);
        check("badcrc_update",  b32.cfg_update, 0);
        check("badcrc_valid",   b32.cfg_valid,  1);

        // Readback of cfg_q = 0x00000001 -> 0x00000001_07 on dout
        capture32();
        rb = '0;
        for (int i = 0; i < 40; i++) begin
            rb = {rb[38:0], b32.dout};
            b32.sen = 1'b1;
            b32.din = 1'b0;
            @(negedge clk);
        end
        b32.sen = 1'b0;
        check("readback_stream",  rb,          {32'h0000_0001, 8'h07});
        check("readback_crc_err", b32.crc_err, 1);

        // Capture again to restart the counter, then good frame 0 / CRC 0
        capture32();
        shift32(64'h0, 40, 1'b0);
        latch32();
        check("good0_cfg_q",   b32.cfg_q,      64'h0);
        check("good0_update",  b32.cfg_update, 1);
        check("good0_crc_err", b32.crc_err,    0);
        check("good0_len_err", b32.len_err,    0);

        // Short frame: 39 bits
        shift32({32'h0000_0001, 8'h07}, 39, 1'b0);
        latch32();
        check("len39_len_err", b32.len_err,    1);
        check("len39_crc_err", b32.crc_err,    0);
        check("len39_cfg_q",   b32.cfg_q,      64'h0);
        check("len39_update",  b32.cfg_update, 0);

        // Long frame: 41 bits, the last 40 of which form a valid frame
        shift32({1'b0, 32'h0000_0001, 8'h07}, 41, 1'b0);
        latch32();
        check("len41_len_err", b32.len_err, 1);
        check("len41_crc_err", b32.crc_err, 0);
        check("len41_cfg_q",   b32.cfg_q,   64'h0);

        // Good frame 0x00000080 / CRC 0x89 clears the flags
        shift32({32'h0000_0080, 8'h89}, 40, 1'b0);
        latch32();
        check("good80_cfg_q",   b32.cfg_q,   64'h80);
        check("good80_len_err", b32.len_err, 0);
        check("good80_crc_err", b32.crc_err, 0);

        // Latch held during shifting has no effect
        shift32({32'h0000_0001, 8'h07}, 40, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("prio_cfg_q",  b32.cfg_q,      64'h80);
        check("prio_update", b32.cfg_update, 0);
        // The frame is intact, so a proper latch now commits it
        latch32();
        check("prio_late_cfg_q",  b32.cfg_q,      64'h1);
        check("prio_late_update", b32.cfg_update, 1);

        // CRC_EN=0, WIDTH=8 instance: shift 0xA5, latch
        check("w8_valid_before", b8.cfg_valid, 0);
        for (int i = 7; i >= 0; i--) begin
            b8.sen = 1'b1;
            b8.din = (i % 3 == 1) ? 1'b0 : 1'b0;
            b8.din = ((8'hA5 >> i) & 8'h01) != 8'h00;
            @(negedge clk);
        end
        b8.sen   = 1'b0;
        b8.din   = 1'b0;
        b8.latch = 1'b1;
        @(negedge clk);
        b8.latch = 1'b0;
        @(negedge clk);
        check("w8_cfg_q",   b8.cfg_q,      64'hA5);
        check("w8_valid",   b8.cfg_valid,  1);
        check("w8_update",  b8.cfg_update, 1);
        check("w8_len_err", b8.len_err,    0);
        check("w32_untouched_by_w8", b32.cfg_q, 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
